// File: rtl/usrt_pkg.sv
// Shared definitions for the USRT transmitter and receiver: state encodings,
// parity codes, frame length and the parity helper.
package usrt_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  localparam int FRAME_BITS = 11;

  // Value the parity slot must carry for byte d under the given mode.
  function automatic logic parity_calc(input logic [7:0] d, input logic [1:0] mode);
    case (mode)
      PAR_EVEN: return ^d;
      PAR_ODD:  return ~(^d);
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rxdeframe.sv
// Serial frame receiver: start, D7..D0, parity slot, stop, sampled on i_Bit_en.
// Optional error counter enabled by defining RXDEFRAME_ERRCNT_EN.
module rxdeframe
  import usrt_pkg::*;
(
  input  logic       i_Pclk,
  input  logic       i_Rst,
  input  logic       i_Bit_en,
  input  logic       i_Rx,
  input  logic [1:0] i_Parity,
`ifdef RXDEFRAME_ERRCNT_EN
  input  logic       i_Err_clr,
  output logic [7:0] o_Err_cnt,
`endif
  output logic [7:0] o_Data,
  output logic       o_Valid,
  output logic       o_Parity_err,
  output logic       o_Frame_err,
  output logic       o_Busy
);

  state_t     state_r, state_n;
  logic [2:0] cnt_r;
  logic [7:0] shift_r;
  logic [1:0] mode_r;
  logic       slot_r;
  logic       pend_r;
  logic       pend_perr_r;
  logic       pend_ferr_r;
  logic [7:0] data_r;
  logic       valid_r;
  logic       perr_r;
  logic       ferr_r;
  logic       busy_s;
  logic       perr_s;

  // State register
  always_ff @(posedge i_Pclk) begin
    if (i_Rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Next-state logic, advancing only on bit strobes
  always_comb begin
    state_n = state_r;
    if (i_Bit_en) begin
      case (state_r)
        IDLE:    state_n = i_Rx ? IDLE : DATA;
        DATA:    state_n = (cnt_r == 3'd7) ? PARITY : DATA;
        PARITY:  state_n = STOP;
        STOP:    state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end else begin
      state_n = state_r;
    end
  end

  // Output decode and parity check against the mode latched at the start bit
  always_comb begin
    busy_s = (state_r != IDLE);
    if ((mode_r == PAR_EVEN) || (mode_r == PAR_ODD)) begin
      perr_s = (parity_calc(shift_r, mode_r) != slot_r);
    end else begin
      perr_s = 1'b0;
    end
  end

  // Frame datapath; results are staged in pend_* so o_Valid lands one edge
  // after the stop sample, independent of the strobe.
  always_ff @(posedge i_Pclk) begin
    if (i_Rst) begin
      cnt_r       <= 3'd0;
      shift_r     <= 8'h00;
      mode_r      <= PAR_NONE;
      slot_r      <= 1'b0;
      pend_r      <= 1'b0;
      pend_perr_r <= 1'b0;
      pend_ferr_r <= 1'b0;
      data_r      <= 8'h00;
      valid_r     <= 1'b0;
      perr_r      <= 1'b0;
      ferr_r      <= 1'b0;
    end else begin
      pend_r  <= 1'b0;
      valid_r <= pend_r;
      if (pend_r) begin
        data_r <= shift_r;
        perr_r <= pend_perr_r;
        ferr_r <= pend_ferr_r;
      end
      if (i_Bit_en) begin
        case (state_r)
          IDLE: begin
            if (!i_Rx) begin
              mode_r <= i_Parity;
              cnt_r  <= 3'd0;
            end
          end
          DATA: begin
            shift_r <= {shift_r[6:0], i_Rx};
            cnt_r   <= cnt_r + 3'd1;
          end
          PARITY: slot_r <= i_Rx;
          STOP: begin
            pend_r      <= 1'b1;
            pend_perr_r <= perr_s;
            pend_ferr_r <= ~i_Rx;
          end
          default: ;
        endcase
      end
    end
  end

  assign o_Data       = data_r;
  assign o_Valid      = valid_r;
  assign o_Parity_err = perr_r;
  assign o_Frame_err  = ferr_r;
  assign o_Busy       = busy_s;

`ifdef RXDEFRAME_ERRCNT_EN
  logic [7:0] err_cnt_r;

  // Saturating count of erroring frames; clear wins over increment
  always_ff @(posedge i_Pclk) begin
    if (i_Rst) begin
      err_cnt_r <= 8'h00;
    end else if (i_Err_clr) begin
      err_cnt_r <= 8'h00;
    end else if (valid_r && (perr_r || ferr_r) && (err_cnt_r != 8'hFF)) begin
      err_cnt_r <= err_cnt_r + 8'd1;
    end
  end

  assign o_Err_cnt = err_cnt_r;
`endif

endmodule

// File: tb/tb_rxdeframe.sv
// Directed self-checking bench for rxdeframe; covers the error counter when
// RXDEFRAME_ERRCNT_EN is defined.
module tb_rxdeframe;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       bit_en = 1'b0;
  logic       rx = 1'b1;
  logic [1:0] parity = 2'b00;
  logic [7:0] data;
  logic       valid, perr, ferr, busy;
`ifdef RXDEFRAME_ERRCNT_EN
  logic       err_clr = 1'b0;
  logic [7:0] err_cnt;
`endif

  int errors = 0;
  int checks = 0;
  int vcount = 0;
  int wide = 0;
  logic prev_valid = 1'b0;
  logic [7:0] vq[$];

  always #5 clk = ~clk;

  rxdeframe dut (
    .i_Pclk      (clk),
    .i_Rst       (rst),
    .i_Bit_en    (bit_en),
    .i_Rx        (rx),
    .i_Parity    (parity),
`ifdef RXDEFRAME_ERRCNT_EN
    .i_Err_clr   (err_clr),
    .o_Err_cnt   (err_cnt),
`endif
    .o_Data      (data),
    .o_Valid     (valid),
    .o_Parity_err(perr),
    .o_Frame_err (ferr),
    .o_Busy      (busy)
  );

  // Pulse monitor: counts o_Valid pulses, records data, flags wide pulses
  always @(negedge clk) begin
    if (valid) begin
      vcount++;
      vq.push_back(data);
    end
    if (valid && prev_valid) wide++;
    prev_valid = valid;
  end

  task automatic bit_slot(input logic b, input int period);
    for (int k = 1; k < period; k++) begin
      @(negedge clk);
      bit_en = 1'b0;
    end
    @(negedge clk);
    bit_en = 1'b1;
    rx = b;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic [1:0] mode,
                            input logic [1:0] mid_mode, input logic par,
                            input logic stop, input int period);
    parity = mode;
    bit_slot(1'b0, period);
    for (int i = 7; i >= 0; i--) begin
      bit_slot(d[i], period);
      if (i == 7) parity = mid_mode;
    end
    bit_slot(par, period);
    bit_slot(stop, period);
  endtask

  task automatic end_frame();
    @(negedge clk);
    bit_en = 1'b0;
    rx = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (data !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", data); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid); end
    checks++; if (perr !== 1'b0) begin errors++; $display("FAIL reset_perr got=%b exp=0", perr); end
    checks++; if (ferr !== 1'b0) begin errors++; $display("FAIL reset_ferr got=%b exp=0", ferr); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_even();
    send_frame(8'hA5, 2'b01, 2'b01, 1'b0, 1'b1, 1);
    end_frame();
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL even_early_valid got=%b exp=0", valid); end
    @(negedge clk);
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL even_valid got=%b exp=1", valid); end
    checks++; if (data !== 8'hA5) begin errors++; $display("FAIL even_data got=%h exp=a5", data); end
    checks++; if (perr !== 1'b0) begin errors++; $display("FAIL even_perr got=%b exp=0", perr); end
    checks++; if (ferr !== 1'b0) begin errors++; $display("FAIL even_ferr got=%b exp=0", ferr); end
    @(negedge clk);
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL even_valid_drop got=%b exp=0", valid); end
    checks++; if (data !== 8'hA5) begin errors++; $display("FAIL even_data_hold got=%h exp=a5", data); end
  endtask

  task automatic test_odd();
    send_frame(8'h01, 2'b10, 2'b10, 1'b1, 1'b1, 1);
    end_frame();
    @(negedge clk);
    checks++; if (valid !== 1'b1 || perr !== 1'b1) begin errors++; $display("FAIL odd_bad got valid=%b perr=%b exp 1 1", valid, perr); end
    send_frame(8'h01, 2'b10, 2'b10, 1'b0, 1'b1, 1);
    end_frame();
    @(negedge clk);
    checks++; if (valid !== 1'b1 || perr !== 1'b0) begin errors++; $display("FAIL odd_good got valid=%b perr=%b exp 1 0", valid, perr); end
    checks++; if (data !== 8'h01) begin errors++; $display("FAIL odd_data got=%h exp=01", data); end
  endtask

  task automatic test_none_frame();
    send_frame(8'h3C, 2'b00, 2'b00, 1'b1, 1'b0, 1);
    end_frame();
    @(negedge clk);
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL none_valid got=%b exp=1", valid); end
    checks++; if (ferr !== 1'b1) begin errors++; $display("FAIL none_ferr got=%b exp=1", ferr); end
    checks++; if (perr !== 1'b0) begin errors++; $display("FAIL none_perr got=%b exp=0", perr); end
    checks++; if (data !== 8'h3C) begin errors++; $display("FAIL none_data got=%h exp=3c", data); end
  endtask

  task automatic test_mode_latch();
    // Even frame with a correct slot; i_Parity switches to odd mid-frame
    send_frame(8'h01, 2'b01, 2'b10, 1'b1, 1'b1, 1);
    end_frame();
    @(negedge clk);
    checks++; if (valid !== 1'b1 || perr !== 1'b0) begin errors++; $display("FAIL mode_latch got valid=%b perr=%b exp 1 0", valid, perr); end
    checks++; if (ferr !== 1'b0) begin errors++; $display("FAIL mode_latch_ferr got=%b exp=0", ferr); end
  endtask

  task automatic test_back_to_back();
    repeat (3) @(negedge clk);
    vq.delete(); vcount = 0; wide = 0;
    send_frame(8'h55, 2'b01, 2'b01, 1'b0, 1'b1, 4);
    send_frame(8'hAA, 2'b01, 2'b01, 1'b0, 1'b1, 4);
    end_frame();
    repeat (10) @(negedge clk);
    checks++; if (vcount !== 2) begin errors++; $display("FAIL b2b4_count got=%0d exp=2", vcount); end
    checks++; if (vq.size() != 2 || vq[0] !== 8'h55 || vq[1] !== 8'hAA) begin errors++; $display("FAIL b2b4_order got=%p exp={55,aa}", vq); end
    checks++; if (wide !== 0) begin errors++; $display("FAIL b2b4_width got=%0d wide pulses exp=0", wide); end
    checks++; if (data !== 8'hAA || perr !== 1'b0) begin errors++; $display("FAIL b2b4_hold got data=%h perr=%b exp aa 0", data, perr); end
    vq.delete(); vcount = 0;
    send_frame(8'h12, 2'b01, 2'b01, 1'b0, 1'b1, 1);
    send_frame(8'h34, 2'b01, 2'b01, 1'b1, 1'b1, 1);
    end_frame();
    repeat (4) @(negedge clk);
    checks++; if (vcount !== 2) begin errors++; $display("FAIL b2b1_count got=%0d exp=2", vcount); end
    checks++; if (vq.size() != 2 || vq[0] !== 8'h12 || vq[1] !== 8'h34) begin errors++; $display("FAIL b2b1_order got=%p exp={12,34}", vq); end
    checks++; if (perr !== 1'b0 || wide !== 0) begin errors++; $display("FAIL b2b1_flags got perr=%b wide=%0d exp 0 0", perr, wide); end
  endtask

  task automatic test_mid_reset();
    logic [7:0] d;
    d = 8'hC3;
    vcount = 0;
    parity = 2'b01;
    bit_slot(1'b0, 1);
    for (int i = 7; i >= 4; i--) bit_slot(d[i], 1);
    @(negedge clk);
    bit_en = 1'b1;
    rx = 1'b1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before got=%b exp=1", busy); end
    rst = 1'b1;
    @(negedge clk);
    bit_en = 1'b0;
    checks++; if (busy !== 1'b0 || data !== 8'h00 || valid !== 1'b0 || perr !== 1'b0 || ferr !== 1'b0) begin
      errors++; $display("FAIL midrst_outputs got busy=%b data=%h valid=%b perr=%b ferr=%b exp all 0", busy, data, valid, perr, ferr);
    end
    rst = 1'b0;
    repeat (15) @(negedge clk);
    checks++; if (vcount !== 0) begin errors++; $display("FAIL midrst_no_valid got=%0d exp=0", vcount); end
    send_frame(8'hC3, 2'b01, 2'b01, 1'b0, 1'b1, 1);
    end_frame();
    @(negedge clk);
    checks++; if (valid !== 1'b1 || data !== 8'hC3 || perr !== 1'b0 || ferr !== 1'b0) begin
      errors++; $display("FAIL midrst_next got valid=%b data=%h perr=%b ferr=%b exp 1 c3 0 0", valid, data, perr, ferr);
    end
  endtask

`ifdef RXDEFRAME_ERRCNT_EN
  task automatic test_err_cnt();
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checks++; if (err_cnt !== 8'h00) begin errors++; $display("FAIL errcnt_clear got=%h exp=00", err_cnt); end
    send_frame(8'h01, 2'b01, 2'b01, 1'b0, 1'b1, 1);
    end_frame();
    repeat (3) @(negedge clk);
    checks++; if (err_cnt !== 8'h01) begin errors++; $display("FAIL errcnt_one got=%h exp=01", err_cnt); end
    for (int f = 0; f < 299; f++) begin
      send_frame(8'h01, 2'b01, 2'b01, 1'b0, 1'b1, 1);
      end_frame();
    end
    repeat (3) @(negedge clk);
    checks++; if (err_cnt !== 8'hFF) begin errors++; $display("FAIL errcnt_sat got=%h exp=ff", err_cnt); end
    send_frame(8'h01, 2'b01, 2'b01, 1'b0, 1'b1, 1);
    end_frame();
    @(negedge clk);
    checks++; if (valid !== 1'b1 || perr !== 1'b1) begin errors++; $display("FAIL errcnt_pulse got valid=%b perr=%b exp 1 1", valid, perr); end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checks++; if (err_cnt !== 8'h00) begin errors++; $display("FAIL errcnt_clr_wins got=%h exp=00", err_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_even();
    test_odd();
    test_none_frame();
    test_mode_latch();
    test_back_to_back();
    test_mid_reset();
`ifdef RXDEFRAME_ERRCNT_EN
    test_err_cnt();
`endif
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rxdeframe.md
RXDEFRAME -- requirements
Module: rxdeframe

Interface
REQ-001 SHALL have port i_Pclk  input  1  sole clock; all state changes on its rising edge.
REQ-002 SHALL have port i_Rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port i_Bit_en  input  1  bit strobe; i_Rx is sampled only on edges where i_Bit_en=1.
REQ-004 SHALL have port i_Rx  input  1  serial line, idle high.
REQ-005 SHALL have port i_Parity  input  2  parity type: 01 even, 10 odd, 00/11 none.
REQ-006 SHALL have port o_Data  output  8  last received data byte.
REQ-007 SHALL have port o_Valid  output  1  one-cycle pulse: o_Data and the error flags are updated.
REQ-008 SHALL have port o_Parity_err  output  1  parity mismatch for the frame flagged by o_Valid.
REQ-009 SHALL have port o_Frame_err  output  1  stop bit sampled low for the frame flagged by o_Valid.
REQ-010 SHALL have port o_Busy  output  1  high whenever the state is not IDLE.

Function
REQ-011 SHALL accept an 11-bit frame, in line order: start(0), D7..D0 (MSB first), parity slot, stop(1).
REQ-012 SHALL use four states, IDLE, DATA, PARITY and STOP, and advance only on edges where i_Bit_en=1.
REQ-013 SHALL, in IDLE, when a sample reads i_Rx=0, latch i_Parity, clear the bit counter and enter DATA.
REQ-014 SHALL, in IDLE, when a sample reads i_Rx=1, stay in IDLE.
REQ-015 SHALL, in DATA, shift the sample into the data shift register and increment a 3-bit counter.
REQ-016 SHALL leave DATA for PARITY on the 8th DATA sample (counter=7).
REQ-017 SHALL, in PARITY, capture the parity slot and enter STOP.
REQ-018 SHALL, in STOP, sample the stop bit and return to IDLE.
REQ-019 SHALL, on the edge after the STOP sample, pulse o_Valid for exactly one clock and load o_Data and both error flags.
REQ-020 SHALL set o_Parity_err=1 in even mode when (XOR of D7..D0) is not equal to the parity slot.
REQ-021 SHALL set o_Parity_err=1 in odd mode when ~(XOR of D7..D0) is not equal to the parity slot.
REQ-022 SHALL hold o_Parity_err=0 in none mode; the parity slot is still consumed.
REQ-023 SHALL set o_Frame_err=1 when the stop sample is 0; o_Valid still pulses and o_Data is still loaded.
REQ-024 SHALL hold o_Data and both error flags between o_Valid pulses.
REQ-025 SHALL keep o_Valid low on every other cycle.
REQ-026 SHALL use the parity mode latched at the start bit; changes to i_Parity mid-frame have no effect on that frame.
REQ-027 SHALL let a start bit sampled on the edge after the STOP sample begin a new frame, so back-to-back frames are received with no idle bit.
REQ-028 SHALL freeze state, counters and outputs while i_Bit_en=0, except that o_Valid deasserts after its one-cycle pulse.

Reset
REQ-029 SHALL, while i_Rst=1 at an edge, force the state to IDLE and the counter and shift register to 0.
REQ-030 SHALL, while i_Rst=1 at an edge, force o_Data=8'h00 and o_Valid, o_Parity_err, o_Frame_err and o_Busy to 0.
REQ-031 SHALL discard a frame when reset arrives mid-frame, with no o_Valid for it.
REQ-032 SHALL take reset priority over i_Bit_en.

Configuration
REQ-033 SHALL, with RXDEFRAME_ERRCNT_EN defined, add input i_Err_clr (1 bit) and output o_Err_cnt (8 bits).
REQ-034 SHALL, with RXDEFRAME_ERRCNT_EN defined, increment o_Err_cnt by 1 on each o_Valid with either error flag set, saturating at 8'hFF.
REQ-035 SHALL, with RXDEFRAME_ERRCNT_EN defined, zero o_Err_cnt on i_Err_clr=1 (clear wins over a simultaneous increment) and on reset.
REQ-036 SHALL, without RXDEFRAME_ERRCNT_EN, have neither port nor counter, with all other behaviour identical.

Structure
REQ-037 SHALL define the following in shared package usrt_pkg, which the transmitter also uses:
- state encodings IDLE/DATA/PARITY/STOP;
- parity codes PAR_NONE=2'b00, PAR_EVEN=2'b01, PAR_ODD=2'b10;
- frame length constant FRAME_BITS=11.
REQ-038 SHALL be implemented as a single module with no sub-modules; the parity computation is a package function shared with the transmitter.

Verification
REQ-039 SHALL cover: even mode, i_Bit_en=1 every cycle, line 0,1010_0101,0,1 -> o_Valid pulse one cycle after the stop sample, o_Data=8'hA5, both error flags 0.
REQ-040 SHALL cover: odd mode, byte 8'h01, parity slot 1 -> o_Parity_err=1; same byte with parity slot 0 -> o_Parity_err=0.
REQ-041 SHALL cover: none mode, byte 8'h3C, stop sampled 0 -> o_Frame_err=1, o_Parity_err=0, o_Data=8'h3C, o_Valid pulses.
REQ-042 SHALL cover: i_Bit_en=1 every 4th cycle, two back-to-back frames 8'h55 then 8'hAA -> exactly two o_Valid pulses, each one cycle wide, with o_Data in order.
REQ-043 SHALL cover: reset asserted after D4 of a frame -> no o_Valid, all outputs 0; the next full frame 8'hC3 is received correctly.
REQ-044 SHALL cover, with RXDEFRAME_ERRCNT_EN: 300 frames with parity errors -> o_Err_cnt=8'hFF; i_Err_clr asserted together with an erroring o_Valid -> o_Err_cnt=0.
